hazard_control_unit: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV64 core. It sits beside the Execute stage.
- Detects load-use hazards against the ID/EX load and resolves taken branches in EX.
- Honours data-memory wait. Drives PC, IF/ID, ID/EX and EX/MEM write-enables, flushes, bubble insertion and next-PC select.
- Forwarding (EX/MEM, MEM/WB) is handled elsewhere. This block only stalls or squashes where forwarding cannot help.

---
 rtl/hazard_control_unit.sv | 211 +++++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
`default_nettype none
//============================================================================
// Module      : hazard_control_unit
// Description : Pipeline sequencing controller for the 5-stage RV64 core.
//               Detects load-use hazards against the ID/EX load, resolves
//               taken branches in EX and honours data-memory wait by
//               driving pipeline write-enables, flushes, bubbles and the
//               next-PC select. All control outputs are combinational.
//               Optional performance counters are built when the macro
//               HAZARD_PERF_CNT_EN is defined; otherwise they read as zero.
// Revision    : 1.0 - initial release
//============================================================================
module hazard_control_unit #(
    parameter int LOAD_STALL_CYCLES = 1,  // bubbles per load-use hazard (1..3)
    parameter int BRANCH_PENALTY    = 1   // IF/ID flush cycles per taken branch (1..4)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rd,
    input  logic        ex_branch,
    input  logic        ex_zero,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        pc_src,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_write,
    output logic        id_ex_bubble,
    output logic        ex_mem_write,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_STALL = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;
    localparam logic [1:0] c_ST_WAIT  = 2'd3;

    // Extra cycles beyond the first one spent in STALL / FLUSH
    localparam logic       c_MULTI_STALL  = (LOAD_STALL_CYCLES > 1);
    localparam logic       c_MULTI_FLUSH  = (BRANCH_PENALTY > 1);
    localparam logic [1:0] c_STALL_RELOAD = (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;
    localparam logic [1:0] c_FLUSH_RELOAD = (BRANCH_PENALTY > 1) ? 2'(BRANCH_PENALTY - 2) : 2'd0;

    logic [1:0] r_state;
    logic [1:0] r_saved_state;
    logic [1:0] r_cnt;

    logic [1:0] w_state_nxt;
    logic [1:0] w_saved_nxt;
    logic [1:0] w_cnt_nxt;
    logic [1:0] w_eff_state;
    logic       w_load_use;
    logic       w_taken;

    logic w_pc_write;
    logic w_pc_src;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_write;
    logic w_id_ex_bubble;
    logic w_ex_mem_write;

    // Hazard terms: a load to x0 never creates a dependency
    assign w_load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                        ((id_ex_rd == id_rs1) || (id_uses_rs2 && (id_ex_rd == id_rs2)));
    assign w_taken    = ex_branch && ex_zero;

    // On release from WAIT the saved state is executed in the same cycle
    assign w_eff_state = (r_state == c_ST_WAIT) ? r_saved_state : r_state;

    // Output decode and next-state selection; priority mem_busy > taken > load_use
    always_comb begin
        w_state_nxt    = r_state;
        w_saved_nxt    = r_saved_state;
        w_cnt_nxt      = r_cnt;
        w_pc_write     = 1'b1;
        w_pc_src       = 1'b0;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_write  = 1'b1;
        w_id_ex_bubble = 1'b0;
        w_ex_mem_write = 1'b1;

        if (reset) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
            w_state_nxt    = c_ST_RUN;
            w_saved_nxt    = c_ST_RUN;
            w_cnt_nxt      = 2'd0;
        end else if (mem_busy) begin
            // Freeze the whole pipeline; the sequence resumes where it stopped
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_state_nxt    = c_ST_WAIT;
            if (r_state != c_ST_WAIT) begin
                w_saved_nxt = r_state;
            end
        end else begin
            case (w_eff_state)
                c_ST_RUN: begin
                    if (w_taken) begin
                        // Squash the two younger instructions in IF/ID and ID/EX
                        w_pc_src       = 1'b1;
                        w_if_id_flush  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                        w_state_nxt    = c_MULTI_FLUSH ? c_ST_FLUSH : c_ST_RUN;
                        w_cnt_nxt      = c_FLUSH_RELOAD;
                    end else if (w_load_use) begin
                        w_pc_write     = 1'b0;
                        w_if_id_write  = 1'b0;
                        w_id_ex_bubble = 1'b1;
                        w_state_nxt    = c_MULTI_STALL ? c_ST_STALL : c_ST_RUN;
                        w_cnt_nxt      = c_STALL_RELOAD;
                    end else begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
                c_ST_STALL: begin
                    // Hazard is not re-checked until back in RUN
                    w_pc_write     = 1'b0;
                    w_if_id_write  = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    if (r_cnt == 2'd0) begin
                        w_state_nxt = c_ST_RUN;
                    end else begin
                        w_state_nxt = c_ST_STALL;
                        w_cnt_nxt   = r_cnt - 2'd1;
                    end
                end
                c_ST_FLUSH: begin
                    // ID/EX holds a bubble here, so no branch can be taken
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                    if (r_cnt == 2'd0) begin
                        w_state_nxt = c_ST_RUN;
                    end else begin
                        w_state_nxt = c_ST_FLUSH;
                        w_cnt_nxt   = r_cnt - 2'd1;
                    end
                end
                default: begin
                    // A saved WAIT is never recorded; recover to RUN
                    w_state_nxt = c_ST_RUN;
                end
            endcase
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_RUN;
            r_saved_state <= c_ST_RUN;
            r_cnt         <= 2'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_saved_state <= w_saved_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign pc_write     = w_pc_write;
    assign pc_src       = w_pc_src;
    assign if_id_write  = w_if_id_write;
    assign if_id_flush  = w_if_id_flush;
    assign id_ex_write  = w_id_ex_write;
    assign id_ex_bubble = w_id_ex_bubble;
    assign ex_mem_write = w_ex_mem_write;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;
    logic        w_flush_evt;

    assign w_flush_evt = !reset && !mem_busy && (w_eff_state == c_ST_RUN) && w_taken;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
            r_flush_events <= 32'd0;
        end else begin
            if (!w_pc_write && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush_evt && (r_flush_events != 32'hFFFF_FFFF)) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
//============================================================================
// Module      : tb_hazard_control_unit
// Description : Self-checking bench for hazard_control_unit. Two instances
//               (LOAD_STALL_CYCLES/BRANCH_PENALTY = 1/1 and 2/3) share one
//               directed stimulus stream and are checked each cycle against
//               a remaining-cycles behavioural model, plus literal checks.
// Revision    : 1.0 - initial release
//============================================================================
module tb_hazard_control_unit;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs2;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_rd;
    logic       ex_branch;
    logic       ex_zero;
    logic       mem_busy;

    // Output vector order: {pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write}
    localparam logic [6:0] c_O_RESET  = 7'b0001010;
    localparam logic [6:0] c_O_BUSY   = 7'b0000000;
    localparam logic [6:0] c_O_DEF    = 7'b1010101;
    localparam logic [6:0] c_O_BRANCH = 7'b1111111;
    localparam logic [6:0] c_O_FLUSH  = 7'b1011111;
    localparam logic [6:0] c_O_STALL  = 7'b0000111;

    logic        a_pw, a_src, a_ifw, a_iff, a_idw, a_bub, a_emw;
    logic        b_pw, b_src, b_ifw, b_iff, b_idw, b_bub, b_emw;
    logic [31:0] a_stall, a_flush, b_stall, b_flush;
    logic [6:0]  w_out_a, w_out_b;

    assign w_out_a = {a_pw, a_src, a_ifw, a_iff, a_idw, a_bub, a_emw};
    assign w_out_b = {b_pw, b_src, b_ifw, b_iff, b_idw, b_bub, b_emw};

    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .BRANCH_PENALTY(1)) u_dut_a (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_rd(id_ex_rd), .ex_branch(ex_branch), .ex_zero(ex_zero),
        .mem_busy(mem_busy), .pc_write(a_pw), .pc_src(a_src),
        .if_id_write(a_ifw), .if_id_flush(a_iff), .id_ex_write(a_idw),
        .id_ex_bubble(a_bub), .ex_mem_write(a_emw),
        .stall_cycles(a_stall), .flush_events(a_flush)
    );

    hazard_control_unit #(.LOAD_STALL_CYCLES(2), .BRANCH_PENALTY(3)) u_dut_b (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_rd(id_ex_rd), .ex_branch(ex_branch), .ex_zero(ex_zero),
        .mem_busy(mem_busy), .pc_write(b_pw), .pc_src(b_src),
        .if_id_write(b_ifw), .if_id_flush(b_iff), .id_ex_write(b_idw),
        .id_ex_bubble(b_bub), .ex_mem_write(b_emw),
        .stall_cycles(b_stall), .flush_events(b_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining bubble / flush cycles per instance
    int          m_lsc [2] = '{1, 2};
    int          m_bp  [2] = '{1, 3};
    int          m_stall_left [2] = '{0, 0};
    int          m_flush_left [2] = '{0, 0};
    logic [31:0] m_stall_cnt [2] = '{32'd0, 32'd0};
    logic [31:0] m_flush_cnt [2] = '{32'd0, 32'd0};

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        logic       lu, tk, fevt;
        logic [6:0] e;
        logic [6:0] act;
        logic [31:0] act_s, act_f;
        lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
             ((id_ex_rd == id_rs1) || (id_uses_rs2 && (id_ex_rd == id_rs2)));
        tk = ex_branch && ex_zero;
        for (int i = 0; i < 2; i++) begin
            act   = (i == 0) ? w_out_a : w_out_b;
            act_s = (i == 0) ? a_stall : b_stall;
            act_f = (i == 0) ? a_flush : b_flush;
            fevt  = 1'b0;
            if (reset) begin
                e = c_O_RESET;
            end else if (mem_busy) begin
                e = c_O_BUSY;
            end else if (m_flush_left[i] > 0) begin
                e = c_O_FLUSH;
            end else if (m_stall_left[i] > 0) begin
                e = c_O_STALL;
            end else if (tk) begin
                e = c_O_BRANCH;
                fevt = 1'b1;
            end else if (lu) begin
                e = c_O_STALL;
            end else begin
                e = c_O_DEF;
            end
            chk((i == 0) ? "outs_a" : "outs_b", {25'd0, act}, {25'd0, e});
            if (!reset) begin
`ifdef HAZARD_PERF_CNT_EN
                chk((i == 0) ? "stall_cnt_a" : "stall_cnt_b", act_s, m_stall_cnt[i]);
                chk((i == 0) ? "flush_cnt_a" : "flush_cnt_b", act_f, m_flush_cnt[i]);
`else
                chk((i == 0) ? "stall_cnt_a" : "stall_cnt_b", act_s, 32'd0);
                chk((i == 0) ? "flush_cnt_a" : "flush_cnt_b", act_f, 32'd0);
`endif
            end
            // Advance model
            if (reset) begin
                m_stall_left[i] = 0;
                m_flush_left[i] = 0;
                m_stall_cnt[i]  = 32'd0;
                m_flush_cnt[i]  = 32'd0;
            end else begin
                if (!mem_busy) begin
                    if (m_flush_left[i] > 0)      m_flush_left[i]--;
                    else if (m_stall_left[i] > 0) m_stall_left[i]--;
                    else if (tk)                  m_flush_left[i] = m_bp[i] - 1;
                    else if (lu)                  m_stall_left[i] = m_lsc[i] - 1;
                end
                if (!e[6] && m_stall_cnt[i] != 32'hFFFF_FFFF) m_stall_cnt[i]++;
                if (fevt && m_flush_cnt[i] != 32'hFFFF_FFFF) m_flush_cnt[i]++;
            end
        end
    end

    // Apply one input vector for one cycle; returns just after the compare point
    task automatic step(input logic rst, input logic busy, input logic mr,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u2, input logic br, input logic z);
        @(posedge clk);
        #1;
        reset = rst; mem_busy = busy; id_ex_mem_read = mr; id_ex_rd = rd;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; ex_branch = br; ex_zero = z;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic load_use_vec();
        step(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic taken_vec();
        step(1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic busy_vec();
        step(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; mem_busy = 1'b0; id_ex_mem_read = 1'b0; id_ex_rd = 5'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; ex_branch = 1'b0; ex_zero = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lit_reset_a", {25'd0, w_out_a}, {25'd0, c_O_RESET});
        idle();
        chk("lit_first_run_a", {25'd0, w_out_a}, {25'd0, c_O_DEF});

        // Load-use on rs1: one bubble for A, two for B
        load_use_vec();
        chk("lit_lu_a", {25'd0, w_out_a}, {25'd0, c_O_STALL});
        idle();
        chk("lit_lu_next_a", {25'd0, w_out_a}, {25'd0, c_O_DEF});
        chk("lit_lu_stall2_b", {25'd0, w_out_b}, {25'd0, c_O_STALL});
        idle();
        chk("lit_lu_done_b", {25'd0, w_out_b}, {25'd0, c_O_DEF});

        // No hazard: load to x0, or rs2 match with rs2 unused; then rs2 used
        step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("lit_x0_a", {31'd0, a_pw}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("lit_rs2_unused_b", {31'd0, b_pw}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
        chk("lit_rs2_used_a", {31'd0, a_pw}, 32'd0);
        idle();
        idle();

        // Taken branch: B flushes for 3 cycles total
        taken_vec();
        chk("lit_br0_b", {25'd0, w_out_b}, {25'd0, c_O_BRANCH});
        idle();
        chk("lit_br1_b", {25'd0, w_out_b}, {25'd0, c_O_FLUSH});
        chk("lit_br1_a", {25'd0, w_out_a}, {25'd0, c_O_DEF});
        idle();
        chk("lit_br2_b", {25'd0, w_out_b}, {25'd0, c_O_FLUSH});
        idle();
        chk("lit_br3_b", {25'd0, w_out_b}, {25'd0, c_O_DEF});

        // Taken and load-use together: branch wins, no stall
        step(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1);
        chk("lit_br_lu_a", {25'd0, w_out_a}, {25'd0, c_O_BRANCH});
        idle();
        chk("lit_br_lu_next_a", {25'd0, w_out_a}, {25'd0, c_O_DEF});
        idle();
        idle();

        // mem_busy arriving in STALL with nothing left to count
        load_use_vec();
        busy_vec();
        chk("lit_busy_b", {25'd0, w_out_b}, {25'd0, c_O_BUSY});
        busy_vec();
        busy_vec();
        idle();
        chk("lit_resume_stall_b", {25'd0, w_out_b}, {25'd0, c_O_STALL});
        idle();
        chk("lit_resume_run_b", {25'd0, w_out_b}, {25'd0, c_O_DEF});

        // Branch frozen by mem_busy then re-evaluated after release
        step(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
        chk("lit_br_frozen_a", {25'd0, w_out_a}, {25'd0, c_O_BUSY});
        taken_vec();
        chk("lit_br_released_b", {25'd0, w_out_b}, {25'd0, c_O_BRANCH});
        idle();
        idle();
        idle();

        // mem_busy in the middle of a flush
        taken_vec();
        busy_vec();
        idle();
        chk("lit_flush_resume_b", {25'd0, w_out_b}, {25'd0, c_O_FLUSH});
        idle();
        idle();
        chk("lit_flush_end_b", {25'd0, w_out_b}, {25'd0, c_O_DEF});

        // Reset in FLUSH abandons the sequence
        taken_vec();
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        chk("lit_reset_flush_b", {25'd0, w_out_b}, {25'd0, c_O_RESET});
        idle();
        chk("lit_post_reset_b", {25'd0, w_out_b}, {25'd0, c_O_DEF});
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
